// File: rtl/ibex_fpu_seq.sv
// Issue/writeback sequencer for the combinational ibex FPU: holds operands for an
// op-dependent number of cycles, then emits one regfile write and accumulates fflags.
package ibex_fpu_seq_pkg;
    typedef enum logic [4:0] {
        FPNOP         = 5'd0,
        FPU_ADD       = 5'd1,
        FPU_SUB       = 5'd2,
        FPU_MUL       = 5'd3,
        FPU_DIV       = 5'd4,
        FPU_SQRT      = 5'd5,
        FPU_MADD      = 5'd6,
        FPU_MSUB      = 5'd7,
        FPU_NMADD     = 5'd8,
        FPU_NMSUB     = 5'd9,
        FPU_SGNJ      = 5'd10,
        FPU_SGNJN     = 5'd11,
        FPU_SGNJX     = 5'd12,
        FPU_MIN       = 5'd13,
        FPU_MAX       = 5'd14,
        FPU_FLOAT2INT = 5'd15,
        FPU_INT2FLOAT = 5'd16,
        FPU_MOVE_F2I  = 5'd17,
        FPU_MOVE_I2F  = 5'd18,
        FPU_CLASS     = 5'd19,
        FPU_EQ        = 5'd20,
        FPU_LT        = 5'd21,
        FPU_LE        = 5'd22
    } fpu_op_e;
endpackage

module ibex_fpu_seq
    import ibex_fpu_seq_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_MAC  = 3,
    parameter int unsigned LAT_DIV  = 8,
    parameter int unsigned LAT_SQRT = 8,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  fpu_op_e     req_op_i,
    input  logic [2:0]  req_rm_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    input  logic [31:0] req_rs3_i,
    input  logic [31:0] req_rs1_int_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output fpu_op_e     fpu_op_o,
    output logic [2:0]  fpu_rm_o,
    output logic [31:0] fpu_rs1_o,
    output logic [31:0] fpu_rs2_o,
    output logic [31:0] fpu_rs3_o,
    output logic [31:0] fpu_rs1_int_o,
    output logic [4:0]  fpu_rd_o,
    input  logic        fpu_fp_write_i,
    input  logic [31:0] fpu_fp_wdata_i,
    input  logic        fpu_int_write_i,
    input  logic [31:0] fpu_int_wdata_i,
    input  logic [7:0]  fpu_status_i,
    output logic        fp_we_o,
    output logic [4:0]  fp_waddr_o,
    output logic [31:0] fp_wdata_o,
    output logic        int_we_o,
    output logic [4:0]  int_waddr_o,
    output logic [31:0] int_wdata_o,
    output logic [4:0]  fflags_o,
    input  logic        fflags_clr_i,
    output logic        busy_o
);

    function automatic int unsigned max2(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned LAT_MAX = max2(max2(max2(LAT_ADD, LAT_MUL), max2(LAT_MAC, LAT_DIV)),
                                           max2(LAT_SQRT, LAT_MISC));
    localparam int unsigned CW = $clog2(LAT_MAX) + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    fpu_op_e     op_q, op_d;
    logic [2:0]  rm_q, rm_d;
    logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d, rs1_int_q, rs1_int_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_fp_we_q, wb_fp_we_d, wb_int_we_q, wb_int_we_d;
    logic [31:0] wb_fp_wdata_q, wb_fp_wdata_d, wb_int_wdata_q, wb_int_wdata_d;
    logic [4:0]  wb_flags_q, wb_flags_d;
    logic [4:0]  fflags_q, fflags_d;
    logic [4:0]  mapped_flags;
    logic [4:0]  fflags_base;
    logic        accept;
    logic        unused_status;

    assign unused_status = ^{fpu_status_i[7:6], fpu_status_i[0]};

    function automatic logic [CW-1:0] lat_m1(fpu_op_e op);
        unique case (op)
            FPU_ADD, FPU_SUB:                          return CW'(LAT_ADD - 1);
            FPU_MUL:                                   return CW'(LAT_MUL - 1);
            FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB:  return CW'(LAT_MAC - 1);
            FPU_DIV:                                   return CW'(LAT_DIV - 1);
            FPU_SQRT:                                  return CW'(LAT_SQRT - 1);
            default:                                   return CW'(LAT_MISC - 1);
        endcase
    endfunction

    // DZ only when a finite dividend meets a (signed) zero divisor; the DW inf bit alone
    // is also raised for overflow and inf operands.
    always_comb begin
        mapped_flags = {fpu_status_i[2],
                        fpu_status_i[1] && (op_q == FPU_DIV) && (rs2_q[30:0] == 31'd0)
                            && (rs1_q[30:23] != 8'hFF),
                        fpu_status_i[4], fpu_status_i[3], fpu_status_i[5]};
        unique case (op_q)
            FPNOP, FPU_SGNJ, FPU_SGNJN, FPU_SGNJX,
            FPU_MOVE_F2I, FPU_MOVE_I2F, FPU_CLASS: mapped_flags = 5'd0;
            default: ;
        endcase
    end

    assign req_ready_o = (state_q != S_EXEC) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        rm_d           = rm_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        rs3_d          = rs3_q;
        rs1_int_d      = rs1_int_q;
        rd_d           = rd_q;
        wb_fp_we_d     = wb_fp_we_q;
        wb_int_we_d    = wb_int_we_q;
        wb_fp_wdata_d  = wb_fp_wdata_q;
        wb_int_wdata_d = wb_int_wdata_q;
        wb_flags_d     = wb_flags_q;
        fflags_base    = fflags_clr_i ? 5'd0 : fflags_q;
        fflags_d       = fflags_base;

        unique case (state_q)
            S_EXEC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    op_d    = FPNOP;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    wb_fp_we_d     = fpu_fp_write_i;
                    wb_int_we_d    = fpu_int_write_i;
                    wb_fp_wdata_d  = fpu_fp_wdata_i;
                    wb_int_wdata_d = fpu_int_wdata_i;
                    wb_flags_d     = mapped_flags;
                    state_d        = S_WB;
                end
            end
            S_WB: begin
                fflags_d = fflags_base | wb_flags_q;
                state_d  = S_IDLE;
                op_d     = FPNOP;
            end
            default: ;
        endcase

        // A new request in IDLE or WB overrides the fall-back to IDLE above.
        if (accept) begin
            state_d   = S_EXEC;
            cnt_d     = lat_m1(req_op_i);
            op_d      = req_op_i;
            rm_d      = req_rm_i;
            rs1_d     = req_rs1_i;
            rs2_d     = req_rs2_i;
            rs3_d     = req_rs3_i;
            rs1_int_d = req_rs1_int_i;
            rd_d      = req_rd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            op_q           <= FPNOP;
            rm_q           <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rs3_q          <= '0;
            rs1_int_q      <= '0;
            rd_q           <= '0;
            wb_fp_we_q     <= 1'b0;
            wb_int_we_q    <= 1'b0;
            wb_fp_wdata_q  <= '0;
            wb_int_wdata_q <= '0;
            wb_flags_q     <= '0;
            fflags_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            rm_q           <= rm_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rs3_q          <= rs3_d;
            rs1_int_q      <= rs1_int_d;
            rd_q           <= rd_d;
            wb_fp_we_q     <= wb_fp_we_d;
            wb_int_we_q    <= wb_int_we_d;
            wb_fp_wdata_q  <= wb_fp_wdata_d;
            wb_int_wdata_q <= wb_int_wdata_d;
            wb_flags_q     <= wb_flags_d;
            fflags_q       <= fflags_d;
        end
    end

    assign fpu_op_o      = op_q;
    assign fpu_rm_o      = rm_q;
    assign fpu_rs1_o     = rs1_q;
    assign fpu_rs2_o     = rs2_q;
    assign fpu_rs3_o     = rs3_q;
    assign fpu_rs1_int_o = rs1_int_q;
    assign fpu_rd_o      = rd_q;
    assign fp_we_o       = (state_q == S_WB) && wb_fp_we_q;
    assign int_we_o      = (state_q == S_WB) && wb_int_we_q;
    assign fp_waddr_o    = rd_q;
    assign int_waddr_o   = rd_q;
    assign fp_wdata_o    = wb_fp_wdata_q;
    assign int_wdata_o   = wb_int_wdata_q;
    assign fflags_o      = fflags_q;
    assign busy_o        = (state_q == S_EXEC);

endmodule

// File: tb/tb_ibex_fpu_seq.sv
// Directed bench for ibex_fpu_seq: the bench plays the FPU, a scoreboard checks every
// regfile write (cycle, enables, address, data) and the main thread checks flags/handshake.
module tb_ibex_fpu_seq;
    import ibex_fpu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    fpu_op_e     req_op = FPNOP;
    logic [2:0]  req_rm = '0;
    logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0, req_rs1_int = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    fpu_op_e     fpu_op_o;
    logic [2:0]  fpu_rm_o;
    logic [31:0] fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, fpu_rs1_int_o;
    logic [4:0]  fpu_rd_o;
    logic        fpu_fp_write = 1'b0, fpu_int_write = 1'b0;
    logic [31:0] fpu_fp_wdata = '0, fpu_int_wdata = '0;
    logic [7:0]  fpu_status = '0;
    logic        fp_we_o, int_we_o;
    logic [4:0]  fp_waddr_o, int_waddr_o;
    logic [31:0] fp_wdata_o, int_wdata_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr = 1'b0;
    logic        busy_o;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] cyc = '0;
    logic [54:0] exp_q[$];

    ibex_fpu_seq dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_op_i(req_op), .req_rm_i(req_rm),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rs3_i(req_rs3),
        .req_rs1_int_i(req_rs1_int), .req_rd_i(req_rd), .flush_i(flush),
        .fpu_op_o(fpu_op_o), .fpu_rm_o(fpu_rm_o),
        .fpu_rs1_o(fpu_rs1_o), .fpu_rs2_o(fpu_rs2_o), .fpu_rs3_o(fpu_rs3_o),
        .fpu_rs1_int_o(fpu_rs1_int_o), .fpu_rd_o(fpu_rd_o),
        .fpu_fp_write_i(fpu_fp_write), .fpu_fp_wdata_i(fpu_fp_wdata),
        .fpu_int_write_i(fpu_int_write), .fpu_int_wdata_i(fpu_int_wdata),
        .fpu_status_i(fpu_status),
        .fp_we_o(fp_we_o), .fp_waddr_o(fp_waddr_o), .fp_wdata_o(fp_wdata_o),
        .int_we_o(int_we_o), .int_waddr_o(int_waddr_o), .int_wdata_o(int_wdata_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr), .busy_o(busy_o)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [54:0] mk(input logic [15:0] c, input logic f, input logic i,
                                       input logic [4:0] a, input logic [31:0] d);
        return {c, f, i, a, d};
    endfunction

    // scoreboard monitor: every write must match the oldest expected write
    always @(negedge clk) begin
        if (fp_we_o || int_we_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {9'd0, cyc, fp_we_o, int_we_o, fp_waddr_o, fp_wdata_o}, 64'd0);
            end else begin
                chk("wb_write", {9'd0, cyc, fp_we_o, int_we_o, fp_waddr_o,
                                 (fp_we_o ? fp_wdata_o : int_wdata_o)}, {9'd0, exp_q.pop_front()});
                chk("wb_int_waddr", {59'd0, int_waddr_o}, {59'd0, fp_waddr_o});
            end
        end
    end

    // driver tasks
    task automatic set_fpu(input logic fw, input logic [31:0] fd, input logic iw,
                           input logic [31:0] id, input logic [7:0] st);
        fpu_fp_write = fw; fpu_fp_wdata = fd; fpu_int_write = iw; fpu_int_wdata = id;
        fpu_status = st;
    endtask

    task automatic issue(input fpu_op_e op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd, output logic [15:0] acc);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
        req_rs3 = 32'h1234_5678; req_rs1_int = 32'h0000_00AA; req_rm = 3'd1;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("issue_ready_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_o || fp_we_o || int_we_o || exp_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk({tag, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"},    {63'd0, req_ready_o}, 64'd1);
        chk({tag, "_busy"},     {63'd0, busy_o}, 64'd0);
        chk({tag, "_we"},       {62'd0, fp_we_o, int_we_o}, 64'd0);
        chk({tag, "_fflags"},   {59'd0, fflags_o}, 64'd0);
        chk({tag, "_waddr"},    {54'd0, fp_waddr_o, int_waddr_o}, 64'd0);
        chk({tag, "_wdata"},    {fp_wdata_o, int_wdata_o}, 64'd0);
        chk({tag, "_fpu_op"},   {59'd0, fpu_op_o}, {59'd0, FPNOP});
        chk({tag, "_fpu_regs"}, {fpu_rs1_o, 27'd0, fpu_rd_o}, 64'd0);
    endtask

    initial begin
        logic [15:0] acc, acc2;
        int          busy_cnt;

        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check_reset_state("reset");

        // ADD 1.0 + 2.0 -> 3.0, rd=5, latency 2
        set_fpu(1'b1, 32'h4040_0000, 1'b0, 32'd0, 8'h00);
        issue(FPU_ADD, 32'h3F80_0000, 32'h4000_0000, 5'd5, acc);
        exp_q.push_back(mk(acc + 16'd2, 1'b1, 1'b0, 5'd5, 32'h4040_0000));
        @(negedge clk);
        chk("add_fpu_op", {59'd0, fpu_op_o}, {59'd0, FPU_ADD});
        chk("add_fpu_rs", {fpu_rs1_o, fpu_rs2_o}, 64'h3F80_0000_4000_0000);
        drain("add");
        chk("add_fflags", {59'd0, fflags_o}, 64'd0);

        // DIV 1.0 / 0.0 -> +inf, DZ, busy exactly 8 cycles
        set_fpu(1'b1, 32'h7F80_0000, 1'b0, 32'd0, 8'h02);
        issue(FPU_DIV, 32'h3F80_0000, 32'h0000_0000, 5'd9, acc);
        exp_q.push_back(mk(acc + 16'd8, 1'b1, 1'b0, 5'd9, 32'h7F80_0000));
        busy_cnt = 0;
        @(negedge clk);
        while (busy_o && busy_cnt < 30) begin
            busy_cnt++;
            @(negedge clk);
        end
        chk("div_busy_cycles", 64'(busy_cnt), 64'd8);
        drain("div");
        chk("div_fflags", {59'd0, fflags_o}, 64'b01000);

        // FLOAT2INT 3.0 -> 3 on the integer port, rd=7, latency 1
        set_fpu(1'b0, 32'hDEAD_BEEF, 1'b1, 32'd3, 8'h00);
        issue(FPU_FLOAT2INT, 32'h4040_0000, 32'd0, 5'd7, acc);
        exp_q.push_back(mk(acc + 16'd1, 1'b0, 1'b1, 5'd7, 32'd3));
        drain("f2i");
        chk("f2i_fflags", {59'd0, fflags_o}, 64'b01000);

        // DIV flushed in EXEC cycle 4: no write, flags untouched
        set_fpu(1'b1, 32'h7F80_0000, 1'b0, 32'd0, 8'h06);
        issue(FPU_DIV, 32'h3F80_0000, 32'h0000_0000, 5'd11, acc);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", {63'd0, req_ready_o}, 64'd1);
        chk("flush_busy", {63'd0, busy_o}, 64'd0);
        repeat (12) @(negedge clk);
        chk("flush_fflags", {59'd0, fflags_o}, 64'b01000);

        // two back-to-back MULs: second accepted in the first's WB, writes 3 apart
        set_fpu(1'b1, 32'h40C0_0000, 1'b0, 32'd0, 8'h00);
        issue(FPU_MUL, 32'h4000_0000, 32'h4040_0000, 5'd3, acc);
        exp_q.push_back(mk(acc + 16'd2, 1'b1, 1'b0, 5'd3, 32'h40C0_0000));
        issue(FPU_MUL, 32'h4000_0000, 32'h4040_0000, 5'd4, acc2);
        exp_q.push_back(mk(acc2 + 16'd2, 1'b1, 1'b0, 5'd4, 32'h40C0_0000));
        chk("b2b_accept_gap", {48'd0, acc2 - acc}, 64'd3);
        drain("b2b");

        // clear, then set NV via an invalid ADD
        @(negedge clk);
        fflags_clr = 1'b1;
        @(posedge clk);
        #1 fflags_clr = 1'b0;
        @(negedge clk);
        chk("clr_fflags", {59'd0, fflags_o}, 64'd0);
        set_fpu(1'b1, 32'h7FC0_0000, 1'b0, 32'd0, 8'h04);
        issue(FPU_ADD, 32'h7F80_0000, 32'hFF80_0000, 5'd1, acc);
        exp_q.push_back(mk(acc + 16'd2, 1'b1, 1'b0, 5'd1, 32'h7FC0_0000));
        drain("nv");
        chk("nv_fflags", {59'd0, fflags_o}, 64'b10000);

        // inexact MUL with clear in its WB cycle: result is NX only
        set_fpu(1'b1, 32'h3F80_0002, 1'b0, 32'd0, 8'h20);
        issue(FPU_MUL, 32'h3F80_0001, 32'h3F80_0001, 5'd2, acc);
        exp_q.push_back(mk(acc + 16'd2, 1'b1, 1'b0, 5'd2, 32'h3F80_0002));
        @(negedge clk);
        while (cyc != acc + 16'd2 && cyc < acc + 16'd20) @(negedge clk);
        fflags_clr = 1'b1;
        @(posedge clk);
        #1 fflags_clr = 1'b0;
        @(negedge clk);
        chk("clr_wb_fflags", {59'd0, fflags_o}, 64'b00001);
        drain("nx");

        // sync reset in the middle of a SQRT
        set_fpu(1'b1, 32'h3FB5_04F3, 1'b0, 32'd0, 8'h20);
        issue(FPU_SQRT, 32'h4000_0000, 32'd0, 5'd6, acc);
        repeat (3) @(negedge clk);
        rst_ni = 1'b0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        repeat (12) @(negedge clk);
        chk("midreset_fflags", {59'd0, fflags_o}, 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
